// File: rtl/pwm_duty_scheduler.sv
// Duty-cycle sequencer for a bank of PWM channels: arbitrated target writes, per-period slew,
// and a simultaneous commit on the period wrap. Optional fault latch enabled by PWM_SCHED_FAULT_EN.
module pwm_duty_scheduler #(
    parameter int CHANNELS = 4,
    parameter int BITS     = 8,
    parameter int STEP     = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [CHANNELS-1:0]      req_valid,
    input  logic [CHANNELS*BITS-1:0] req_duty,
    output logic [CHANNELS-1:0]      req_ready,
    output logic [CHANNELS*BITS-1:0] duty,
    output logic                     period_start,
    output logic                     busy
`ifdef PWM_SCHED_FAULT_EN
    ,
    input  logic                     fault,
    output logic                     fault_latched
`endif
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("pwm_duty_scheduler: CHANNELS must be >= 1");
    end
    if ((2 ** BITS) < (CHANNELS + 2)) begin : g_bad_bits
        $error("pwm_duty_scheduler: 2**BITS must be >= CHANNELS+2");
    end
    if (STEP >= (2 ** BITS)) begin : g_bad_step
        $error("pwm_duty_scheduler: STEP must be < 2**BITS");
    end

    localparam int                PTR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [BITS-1:0]   CNT_MAX = {BITS{1'b1}};
    localparam logic [PTR_W-1:0]  LAST_CH = PTR_W'(CHANNELS - 1);
    localparam logic [BITS-1:0]   STEP_U  = BITS'(STEP);
    localparam logic signed [BITS:0] STEP_S = $signed({1'b0, STEP_U});

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    logic [BITS-1:0]   cnt_r;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [PTR_W-1:0]  ch_idx_r;
    logic [BITS-1:0]   target_r [CHANNELS];
    logic [BITS-1:0]   active_r [CHANNELS];
    logic [BITS-1:0]   shadow_r [CHANNELS];

    logic [PTR_W-1:0]  cand_idx_s [CHANNELS];
    logic [CHANNELS-1:0] grant_s;
    logic [PTR_W-1:0]  grant_idx_s;
    logic              grant_any_s;
    logic [PTR_W-1:0]  next_ptr_s;
    logic [BITS-1:0]   slew_s;
    logic              fault_act_s;
    logic              gate_s;

    // Move active one bounded step toward target; difference taken one bit wider and signed.
    function automatic logic [BITS-1:0] slew_f(input logic [BITS-1:0] act,
                                               input logic [BITS-1:0] tgt);
        logic signed [BITS:0] d_v;
        logic [BITS-1:0]      res_v;
        d_v = $signed({1'b0, tgt}) - $signed({1'b0, act});
        if (STEP == 0) begin
            res_v = tgt;
        end else if (d_v > STEP_S) begin
            res_v = act + STEP_U;
        end else if (d_v < -STEP_S) begin
            res_v = act - STEP_U;
        end else begin
            res_v = tgt;
        end
        return res_v;
    endfunction

`ifdef PWM_SCHED_FAULT_EN
    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fault_latched <= 1'b0;
        end else if (fault) begin
            fault_latched <= 1'b1;
        end else begin
            fault_latched <= fault_latched;
        end
    end

    assign fault_act_s = fault | fault_latched;
    assign gate_s      = fault_latched;
`else
    assign fault_act_s = 1'b0;
    assign gate_s      = 1'b0;
`endif

    // Round-robin arbiter: first valid requester at or after rr_ptr wins.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand_idx_s[k] = PTR_W'((int'(rr_ptr_r) + k) % CHANNELS);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (!grant_any_s && req_valid[cand_idx_s[k]]) begin
                grant_any_s             = 1'b1;
                grant_idx_s             = cand_idx_s[k];
                grant_s[cand_idx_s[k]]  = 1'b1;
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    assign next_ptr_s = (grant_idx_s == LAST_CH) ? '0 : grant_idx_s + PTR_W'(1);
    assign req_ready  = gate_s ? '0 : grant_s;
    assign slew_s     = slew_f(active_r[ch_idx_r], target_r[ch_idx_r]);

    // Free-running period counter; period_start is high in the cycle the counter reads zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r        <= '0;
            period_start <= 1'b0;
        end else begin
            cnt_r        <= cnt_r + BITS'(1);
            period_start <= (cnt_r == CNT_MAX);
        end
    end

    // Target capture and pointer advance on each grant.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_r <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                target_r[k] <= '0;
            end
        end else if (fault_act_s) begin
            rr_ptr_r <= rr_ptr_r;
            for (int k = 0; k < CHANNELS; k++) begin
                target_r[k] <= '0;
            end
        end else if (grant_any_s) begin
            rr_ptr_r              <= next_ptr_s;
            target_r[grant_idx_s] <= req_duty[grant_idx_s*BITS +: BITS];
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Sweep FSM: one channel slewed per cycle after the wrap, all duties committed at the next wrap.
    always_ff @(posedge clk) begin
        if (!resetn || fault_act_s) begin
            state_r  <= S_IDLE;
            ch_idx_r <= '0;
            busy     <= 1'b0;
            duty     <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                active_r[k] <= '0;
                shadow_r[k] <= '0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    ch_idx_r <= '0;
                    if (cnt_r == '0) begin
                        state_r <= S_SWEEP;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    active_r[ch_idx_r] <= slew_s;
                    shadow_r[ch_idx_r] <= slew_s;
                    if (ch_idx_r == LAST_CH) begin
                        state_r  <= S_WAIT;
                        ch_idx_r <= '0;
                        busy     <= 1'b0;
                    end else begin
                        state_r  <= S_SWEEP;
                        ch_idx_r <= ch_idx_r + PTR_W'(1);
                        busy     <= 1'b1;
                    end
                end
                S_WAIT: begin
                    busy <= 1'b0;
                    if (cnt_r == CNT_MAX) begin
                        state_r <= S_IDLE;
                        for (int k = 0; k < CHANNELS; k++) begin
                            duty[k*BITS +: BITS] <= shadow_r[k];
                        end
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    ch_idx_r <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler: a slew-limited instance and a STEP=0 instance,
// expected per-wrap duties queued when requests are driven and compared at each wrap.
module tb_pwm_duty_scheduler;
    localparam int CH = 4;
    localparam int B  = 8;
    localparam int ST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [CH-1:0]     req_valid,  req_ready,  req_valid0, req_ready0;
    logic [CH*B-1:0]   req_duty,   duty,       req_duty0,  duty0;
    logic              period_start, busy, period_start0, busy0;
`ifdef PWM_SCHED_FAULT_EN
    logic              fault, fault_latched, fault0, fault_latched0;
`endif

    pwm_duty_scheduler #(.CHANNELS(CH), .BITS(B), .STEP(ST)) u_dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_duty(req_duty),
        .req_ready(req_ready), .duty(duty), .period_start(period_start), .busy(busy)
`ifdef PWM_SCHED_FAULT_EN
        , .fault(fault), .fault_latched(fault_latched)
`endif
    );

    pwm_duty_scheduler #(.CHANNELS(CH), .BITS(B), .STEP(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid0), .req_duty(req_duty0),
        .req_ready(req_ready0), .duty(duty0), .period_start(period_start0), .busy(busy0)
`ifdef PWM_SCHED_FAULT_EN
        , .fault(fault0), .fault_latched(fault_latched0)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [CH*B-1:0] exp_q[$];
    logic [CH*B-1:0] exp0_q[$];
    int m_shadow[CH];
    int m_target[CH];
    int m_rr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int slew_m(input int a, input int t, input int step);
        int d;
        d = t - a;
        if (step == 0) return t;
        if (d > step) return a + step;
        if (d < -step) return a - step;
        return t;
    endfunction

    // Queue the duties of the next n wraps for the slewed instance, advancing the model.
    task automatic plan(input int n);
        logic [CH*B-1:0] v;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < CH; c++) v[c*B +: B] = B'(m_shadow[c]);
            exp_q.push_back(v);
            for (int c = 0; c < CH; c++) m_shadow[c] = slew_m(m_shadow[c], m_target[c], ST);
        end
    endtask

    task automatic wait_wrap(output bit ok, output int cyc);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (period_start === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic drain(input string tag, output int first_cyc);
        bit ok;
        int cyc;
        logic [CH*B-1:0] e;
        first_cyc = -1;
        while (exp_q.size() > 0 || exp0_q.size() > 0) begin
            wait_wrap(ok, cyc);
            if (first_cyc < 0) first_cyc = cyc;
            if (!ok) begin
                check({tag, " wrap_timeout"}, 64'(ok), 64'd1);
                exp_q.delete();
                exp0_q.delete();
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, " duty"}, 64'(duty), 64'(e));
                end
                if (exp0_q.size() > 0) begin
                    e = exp0_q.pop_front();
                    check({tag, " duty0"}, 64'(duty0), 64'(e));
                end
            end
        end
    endtask

    // Single-cycle request from one channel; sel 0 = slewed instance, 1 = STEP=0 instance.
    task automatic do_write(input int sel, input int ch, input int val);
        logic [CH-1:0] e;
        e = '0;
        e[ch] = 1'b1;
        if (sel == 0) begin
            req_valid = e;
            req_duty[ch*B +: B] = B'(val);
            #1;
            check("grant", 64'(req_ready), 64'(e));
            @(negedge clk);
            req_valid = '0;
        end else begin
            req_valid0 = e;
            req_duty0[ch*B +: B] = B'(val);
            #1;
            check("grant0", 64'(req_ready0), 64'(e));
            @(negedge clk);
            req_valid0 = '0;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_shadow[c] = 0;
            m_target[c] = 0;
        end
        m_rr = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fc;
        logic [CH-1:0] eg;
        logic [CH*B-1:0] v;
        resetn = 1'b0;
        req_valid = '0; req_duty = '0; req_valid0 = '0; req_duty0 = '0;
`ifdef PWM_SCHED_FAULT_EN
        fault = 1'b0; fault0 = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check("rst duty", 64'(duty), 64'd0);
        check("rst period_start", 64'(period_start), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst ready", 64'(req_ready), 64'd0);

        // T2: all requesters valid for 8 cycles from rr_ptr=0; also checks busy window
        resetn = 1'b1;
        req_valid = '1;
        req_duty = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            eg = '0;
            eg[m_rr] = 1'b1;
            check("t2 grant", 64'(req_ready), 64'(eg));
            check("t2 busy", 64'(busy), 64'((i >= 1 && i <= 4) ? 1 : 0));
            m_rr = (m_rr + 1) % CH;
            @(negedge clk);
        end
        req_valid = '0;
        plan(1);
        exp0_q.push_back('0);
        drain("t2", fc);
        check("first pulse cycles", 64'(fc), 64'd248);

        // T1: ch0 target 10 written at cnt=200
        repeat (200) @(negedge clk);
        do_write(0, 0, 10);
        m_target[0] = 10;
        plan(4);
        drain("t1", fc);

        // T3: ch1 ramps to 200, then back to 0 at exactly STEP per period
        repeat (200) @(negedge clk);
        do_write(0, 1, 200);
        m_target[1] = 200;
        plan(51);
        drain("t3 up", fc);
        repeat (200) @(negedge clk);
        do_write(0, 1, 0);
        m_target[1] = 0;
        plan(52);
        drain("t3 down", fc);

        // T4: STEP=0 instance, write before ch2 slot (cnt=2) then in its slot (cnt=3)
        repeat (2) @(negedge clk);
        do_write(1, 2, 100);
        v = '0; v[2*B +: B] = 8'd100;
        plan(1);
        exp0_q.push_back(v);
        drain("t4 early", fc);
        repeat (3) @(negedge clk);
        do_write(1, 2, 255);
        plan(2);
        exp0_q.push_back(v);
        v[2*B +: B] = 8'd255;
        exp0_q.push_back(v);
        drain("t4 same", fc);

        // T5: reset asserted during the sweep at cnt=1
        @(negedge clk);
        check("t5 busy pre", 64'(busy), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("t5 duty", 64'(duty), 64'd0);
        check("t5 duty0", 64'(duty0), 64'd0);
        check("t5 busy", 64'(busy), 64'd0);
        check("t5 period_start", 64'(period_start), 64'd0);
        resetn = 1'b1;
        model_reset();
        plan(2);
        exp0_q.push_back('0);
        exp0_q.push_back('0);
        drain("t5", fc);
        check("t5 pulse cycles", 64'(fc), 64'd256);

`ifdef PWM_SCHED_FAULT_EN
        // T6: one-cycle fault with nonzero duty
        repeat (200) @(negedge clk);
        do_write(0, 3, 8);
        m_target[3] = 8;
        plan(3);
        drain("t6 pre", fc);
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        check("t6 duty", 64'(duty), 64'd0);
        check("t6 latched", 64'(fault_latched), 64'd1);
        req_valid = '1;
        #1;
        check("t6 ready", 64'(req_ready), 64'd0);
        begin
            bit ok;
            int cyc;
            wait_wrap(ok, cyc);
            check("t6 period runs", 64'(ok), 64'd1);
        end
        check("t6 duty held", 64'(duty), 64'd0);
        check("t6 latched held", 64'(fault_latched), 64'd1);
        req_valid = '0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("t6 latch cleared", 64'(fault_latched), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
